store_loader: RTL and testbench
===============================

STORE_LOADER -- requirements
Module: store_loader

Interface
REQ-001 Parameter WORDS, default 32: number of store words copied; legal values 1..32.
REQ-002 Parameter AUTO_START, default 1: when 1, the block pulses cpu_run after a clean load.
REQ-003 Port clk, input, 1: the only clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port load_req, input, 1: request to copy the selected program image into the store; sampled while in IDLE.
REQ-006 Port cpu_halted, input, 1: CPU acknowledgement that it is stopped.
REQ-007 Port cpu_stop, output, 1: holds the CPU stopped while the loader owns the store.
REQ-008 Port cpu_run, output, 1: single-cycle restart pulse to the CPU.
REQ-009 Port rom_addr, output, 5: word address into the combinational program image.
REQ-010 Port rom_data, input, 32: image word at rom_addr, valid in the same cycle.
REQ-011 Ports cpu_we (input, 1), cpu_addr (input, 5) and cpu_wdata (input, 32): the CPU store-port request.
REQ-012 Ports store_we (output, 1), store_addr (output, 5) and store_wdata (output, 32): the store write/read port.
REQ-013 Port store_rdata, input, 32: store read data, valid one cycle after store_addr is presented.
REQ-014 Port busy, output, 1: high in every state except IDLE.
REQ-015 Port done, output, 1: single-cycle pulse when a load completes.
REQ-016 Port error, output, 1: sticky flag indicating a verify mismatch.

Function
REQ-017 The FSM SHALL have the states IDLE, HALT, COPY, VRD, VCMP and FIN, plus a 5-bit word counter idx.
REQ-018 IDLE: when load_req=1, the FSM SHALL go to HALT, clear error and set idx=0; load_req in any other state SHALL be ignored.
REQ-019 HALT: cpu_stop=1; the FSM SHALL go to COPY on the first cycle in which cpu_halted=1, and otherwise wait indefinitely.
REQ-020 COPY: store_we=1, store_addr=idx, rom_addr=idx, store_wdata=rom_data; idx SHALL increment each cycle, and the FSM SHALL go to VRD with idx=0 after idx=WORDS-1.
REQ-021 VRD: store_we=0, store_addr=idx, rom_addr=idx; the FSM SHALL go to VCMP.
REQ-022 VCMP: rom_addr=idx; if store_rdata != rom_data then error SHALL be set to 1.
REQ-023 VCMP exit: after idx=WORDS-1 the FSM SHALL go to FIN, otherwise idx SHALL increment and the FSM SHALL return to VRD.
REQ-024 FIN: done=1 for one cycle, cpu_stop SHALL drop the following cycle, and the FSM SHALL return to IDLE.
REQ-025 In FIN, cpu_run SHALL pulse in the same cycle when AUTO_START=1 and error=0.
REQ-026 Latency from the load_req sample to the done pulse SHALL be 1+H+WORDS+2*WORDS+1 cycles, where H is the number of HALT wait cycles (H=0 when cpu_halted is already high), giving 98 cycles for WORDS=32 and H=0.
REQ-027 Arbitration: in IDLE, store_we/addr/wdata SHALL equal cpu_we/addr/wdata combinationally; in all other states the CPU port SHALL be ignored and no CPU write SHALL reach the store.
REQ-028 The error flag SHALL be sticky through FIN and IDLE, and SHALL clear only at the next accepted load_req.
REQ-029 cpu_halted falling during COPY, VRD or VCMP SHALL be ignored; the sequence continues.
REQ-030 rom_addr SHALL be 0 in IDLE and HALT.

Reset
REQ-031 While rst_n=0, the FSM SHALL be in IDLE with idx=0 and busy, done, error, cpu_stop and cpu_run all 0.
REQ-032 Reset asserted mid-load SHALL abort immediately with no further store writes; partially written store contents are undefined and no done or cpu_run is produced.
REQ-033 Release of rst_n SHALL take effect on the next rising clk edge, and the first load_req SHALL be honoured no earlier than that edge.

Verification
REQ-034 Clean load: cpu_halted=1, load_req pulse, store model echoes writes -> 32 writes to addresses 0..31 in order, error=0, done and cpu_run pulse together 98 cycles after the load_req sample.
REQ-035 Halt wait: cpu_halted held low for 5 cycles -> cpu_stop=1 throughout, no store_we until the cycle after cpu_halted rises, done at cycle 103.
REQ-036 Corruption: store model returns word 17 XOR 0x1 -> error rises in VCMP for idx=17, done pulses, cpu_run stays 0, error holds until the next load_req.
REQ-037 Arbitration: cpu_we=1 to address 5 throughout the load -> CPU value never written while busy=1; passes through in the IDLE cycle after FIN.
REQ-038 Abort: rst_n low at COPY idx=10 -> outputs 0 immediately; a new load_req after release completes normally in 98 cycles.
REQ-039 Re-request: load_req held high for the whole load -> exactly one load runs, then a second load starts from the IDLE cycle after FIN.

Source files
------------

// File: rtl/store_loader.sv
// Boot loader: copies a combinational program image into the CPU store while the CPU is held,
// then re-reads every word to verify it and optionally restarts the CPU.
module store_loader #(
  parameter int unsigned WORDS      = 32,
  parameter bit          AUTO_START = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_req,
  input  logic        cpu_halted,
  output logic        cpu_stop,
  output logic        cpu_run,
  output logic [4:0]  rom_addr,
  input  logic [31:0] rom_data,
  input  logic        cpu_we,
  input  logic [4:0]  cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        store_we,
  output logic [4:0]  store_addr,
  output logic [31:0] store_wdata,
  input  logic [31:0] store_rdata,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    StIdle,
    StHalt,
    StCopy,
    StVrd,
    StVcmp,
    StFin
  } state_e;

  localparam logic [4:0] Last = 5'(WORDS - 1);

  state_e     state_q;
  logic [4:0] idx_q;
  logic       mismatch;

  assign mismatch = (store_rdata != rom_data);

  // Status outputs are registered so they change only on clock edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= 5'd0;
      error    <= 1'b0;
      done     <= 1'b0;
      cpu_run  <= 1'b0;
      busy     <= 1'b0;
      cpu_stop <= 1'b0;
    end else begin
      done    <= 1'b0;
      cpu_run <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (load_req) begin
            state_q  <= StHalt;
            idx_q    <= 5'd0;
            error    <= 1'b0;
            busy     <= 1'b1;
            cpu_stop <= 1'b1;
          end
        end
        StHalt: begin
          if (cpu_halted) state_q <= StCopy;
        end
        StCopy: begin
          if (idx_q == Last) begin
            idx_q   <= 5'd0;
            state_q <= StVrd;
          end else begin
            idx_q <= idx_q + 5'd1;
          end
        end
        StVrd: begin
          state_q <= StVcmp;
        end
        StVcmp: begin
          if (mismatch) error <= 1'b1;
          if (idx_q == Last) begin
            idx_q   <= 5'd0;
            state_q <= StFin;
            done    <= 1'b1;
            // Include this cycle's compare so a bad last word still suppresses the restart.
            cpu_run <= AUTO_START && !error && !mismatch;
          end else begin
            idx_q   <= idx_q + 5'd1;
            state_q <= StVrd;
          end
        end
        StFin: begin
          state_q  <= StIdle;
          busy     <= 1'b0;
          cpu_stop <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Store port: the CPU owns it only in IDLE; the loader drives it everywhere else.
  always_comb begin
    store_we    = 1'b0;
    store_addr  = idx_q;
    store_wdata = rom_data;
    rom_addr    = 5'd0;
    unique case (state_q)
      StIdle: begin
        store_we    = cpu_we;
        store_addr  = cpu_addr;
        store_wdata = cpu_wdata;
      end
      StCopy: begin
        store_we = 1'b1;
        rom_addr = idx_q;
      end
      StVrd, StVcmp: begin
        rom_addr = idx_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_store_loader.sv
// Self-checking bench for store_loader: table-driven loads, randomized loads against a
// behavioural model, and hand-written abort / re-request sequences.
module tb_store_loader;

  localparam int W = 32;
  localparam logic [31:0] CpuVal = 32'hC0DE_0005;

  logic        clk, rst_n, load_req, cpu_halted;
  logic        cpu_stop, cpu_run;
  logic [4:0]  rom_addr;
  logic [31:0] rom_data;
  logic        cpu_we;
  logic [4:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic        store_we;
  logic [4:0]  store_addr;
  logic [31:0] store_wdata, store_rdata;
  logic        busy, done, error;

  store_loader #(.WORDS(W), .AUTO_START(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_req   (load_req),
    .cpu_halted (cpu_halted),
    .cpu_stop   (cpu_stop),
    .cpu_run    (cpu_run),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .store_we   (store_we),
    .store_addr (store_addr),
    .store_wdata(store_wdata),
    .store_rdata(store_rdata),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program image and store models.
  logic [31:0] rom [32];
  logic [31:0] mem [32];
  bit          corrupt_en;
  logic [4:0]  corrupt_idx;

  assign rom_data = rom[rom_addr];

  always @(posedge clk) begin
    if (store_we) mem[store_addr] <= store_wdata;
    store_rdata <= mem[store_addr] ^ ((corrupt_en && store_addr == corrupt_idx) ? 32'h1 : 32'h0);
  end

  logic [4:0]  wa_q[$];
  logic [31:0] wd_q[$];
  int          rst_writes;

  always @(posedge clk) begin
    if (store_we && busy) begin
      wa_q.push_back(store_addr);
      wd_q.push_back(store_wdata);
    end
    if (!rst_n && store_we) rst_writes++;
  end

  int checks;
  int errors;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic fill_rom();
    for (int i = 0; i < 32; i++) begin
      rom[i] = $urandom;
      if (rom[i] == CpuVal) rom[i] = ~CpuVal;
    end
  endtask

  // One full load from IDLE; returns in the IDLE cycle after FIN.
  task automatic run_load(input int hdelay, input int cidx, input bit cpu_wr, input int exp_cycle,
                          input bit exp_err, input bit exp_run, input bit hold_req);
    int cyc;
    int halt_bad;
    int err_bad;
    int bad;
    fill_rom();
    corrupt_en  = (cidx >= 0);
    corrupt_idx = (cidx >= 0) ? 5'(cidx) : 5'd0;
    cpu_we      = cpu_wr;
    cpu_addr    = 5'd5;
    cpu_wdata   = CpuVal;
    cpu_halted  = (hdelay == 0);
    wa_q.delete();
    wd_q.delete();
    load_req = 1'b1;
    @(posedge clk); #1;
    cyc = 1;
    if (!hold_req) load_req = 1'b0;
    check1("accept_busy", busy, 1'b1);
    check1("accept_stop", cpu_stop, 1'b1);
    check1("accept_err_clear", error, 1'b0);
    halt_bad = 0;
    err_bad  = 0;
    while (!done && cyc < 400) begin
      if (cyc <= 1 + hdelay && (store_we || !cpu_stop || rom_addr != 5'd0)) halt_bad++;
      if (cpu_run) halt_bad++;
      if (cyc == 1 + hdelay) cpu_halted = 1'b1;
      if (cidx >= 0) begin
        if (cyc == 3 + hdelay + W + 2 * cidx && error) err_bad++;
        if (cyc == 4 + hdelay + W + 2 * cidx && !error) err_bad++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    check("done_cycle", cyc, exp_cycle);
    check1("fin_cpu_run", cpu_run, exp_run);
    check1("fin_error", error, exp_err);
    check1("fin_stop", cpu_stop, 1'b1);
    check("halt_phase", halt_bad, 0);
    if (cidx >= 0) check("error_rise", err_bad, 0);
    check("write_count", wa_q.size(), W);
    bad = 0;
    for (int i = 0; i < wa_q.size(); i++) begin
      if (wa_q[i] != 5'(i) || wd_q[i] != rom[i]) bad++;
    end
    check("write_order", bad, 0);
    @(posedge clk); #1;
    check1("post_done_drop", done, 1'b0);
    check1("post_run_drop", cpu_run, 1'b0);
    check1("post_stop_drop", cpu_stop, 1'b0);
    check1("post_idle_busy", busy, 1'b0);
    check1("post_err_sticky", error, exp_err);
    if (cpu_wr) begin
      check1("pass_we", store_we, 1'b1);
      check("pass_addr", 32'(store_addr), 32'd5);
      check("pass_data", store_wdata, CpuVal);
    end
  endtask

  typedef struct {
    int hdelay;
    int cidx;
    bit cpu_wr;
    int exp_cycle;
    bit exp_err;
    bit exp_run;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int cyc;
    int h;
    int c;
    bit cw;
    checks     = 0;
    errors     = 0;
    rst_writes = 0;
    vecs[0] = '{0, -1, 1'b0, 98, 1'b0, 1'b1};
    vecs[1] = '{5, -1, 1'b0, 103, 1'b0, 1'b1};
    vecs[2] = '{0, 17, 1'b0, 98, 1'b1, 1'b0};
    vecs[3] = '{0, -1, 1'b1, 98, 1'b0, 1'b1};

    rst_n = 1'b0; load_req = 1'b0; cpu_halted = 1'b0;
    cpu_we = 1'b0; cpu_addr = 5'd0; cpu_wdata = 32'd0;
    corrupt_en = 1'b0; corrupt_idx = 5'd0;
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    fill_rom();
    repeat (2) @(posedge clk);
    #1;
    check1("rst_busy", busy, 1'b0);
    check1("rst_done", done, 1'b0);
    check1("rst_error", error, 1'b0);
    check1("rst_stop", cpu_stop, 1'b0);
    check1("rst_run", cpu_run, 1'b0);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 4; v++) begin
      run_load(vecs[v].hdelay, vecs[v].cidx, vecs[v].cpu_wr, vecs[v].exp_cycle,
               vecs[v].exp_err, vecs[v].exp_run, 1'b0);
      cpu_we = 1'b0;
      if (vecs[v].exp_err) begin
        repeat (3) @(posedge clk);
        #1;
        check1("idle_err_hold", error, 1'b1);
      end
    end

    // Randomized loads against the spec-level model.
    for (int r = 0; r < 6; r++) begin
      h  = $urandom_range(0, 6);
      c  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, W - 1)) : -1;
      cw = 1'($urandom_range(0, 1));
      run_load(h, c, cw, 1 + h + W + 2 * W + 1, c >= 0, c < 0, 1'b0);
      cpu_we = 1'b0;
    end

    // Abort mid-copy at idx 10.
    fill_rom();
    corrupt_en = 1'b0; cpu_halted = 1'b1; cpu_we = 1'b0;
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
    cyc = 1;
    while (cyc < 12) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("abort_at_copy10", 32'(store_addr), 32'd10);
    rst_n = 1'b0;
    #1;
    check1("abort_busy", busy, 1'b0);
    check1("abort_done", done, 1'b0);
    check1("abort_stop", cpu_stop, 1'b0);
    check1("abort_run", cpu_run, 1'b0);
    check1("abort_we", store_we, 1'b0);
    rst_writes = 0;
    repeat (2) @(posedge clk);
    #1;
    check("abort_no_writes", rst_writes, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_load(0, -1, 1'b0, 98, 1'b0, 1'b1, 1'b0);

    // Re-request: load_req held through a whole load.
    run_load(0, -1, 1'b0, 98, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    load_req = 1'b0;
    check1("rereq_busy", busy, 1'b1);
    cyc = 1;
    while (!done && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("rereq_done_cycle", cyc, 98);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
